// File: rtl/dpram_bist_ctrl_pkg.sv
// Shared types and constants for the DPRAM march-test sequencer.
// Holds the FSM states, phase and op codes, default geometry and background helpers.
package dpram_pkg;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam logic [DW-1:0] BG = 16'hA5A5;
  localparam int TIMEOUT = 255;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_PASS  = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_W0   = 2'd0,
    PH_R0W1 = 2'd1,
    PH_R1   = 2'd2
  } phase_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Phase 0 writes the background, phase 1 writes its complement.
  function automatic logic [DW-1:0] wr_word(input phase_t ph);
    if (ph == PH_W0) wr_word = BG;
    else             wr_word = ~BG;
  endfunction

  function automatic logic [DW-1:0] rd_word(input phase_t ph);
    if (ph == PH_R1) rd_word = ~BG;
    else             rd_word = BG;
  endfunction

endpackage

// File: rtl/dpram_bist_ctrl_if.sv
// DPRAM port bundle: the sequencer is the master, the memory is the slave.
interface dpram_bist_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic [AW-1:0] A;
  logic [DW-1:0] DIn;
  logic [DW-1:0] DOut;
  logic          RD;
  logic          WR;
  logic          Done;

  modport master (output A, DIn, RD, WR, input Done, DOut);
  modport slave  (input A, DIn, RD, WR, output Done, DOut);
endinterface

// File: rtl/dpram_addr_seq.sv
// Loadable up/down address counter with step enable and direction-aware terminal count.
module dpram_addr_seq
  import dpram_pkg::*;
(
  input  logic          clk,
  input  logic          ar,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_val,
  input  logic          i_step,
  input  logic          i_up,
  output logic [AW-1:0] o_addr,
  output logic          o_tc
);

  logic [AW-1:0] r_addr;

  // Address register: load has priority over stepping.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      r_addr <= {AW{1'b0}};
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (i_step) begin
      r_addr <= i_up ? (r_addr + AW'(1)) : (r_addr - AW'(1));
    end else begin
      r_addr <= r_addr;
    end
  end

  assign o_addr = r_addr;
  assign o_tc   = i_up ? (r_addr == {AW{1'b1}}) : (r_addr == {AW{1'b0}});

endmodule

// File: rtl/dpram_bist_ctrl.sv
// Three-phase march test sequencer for the 1024 x 16 DPRAM; all outputs registered.
// Stops on the first miscompare or missing Done and records where it happened.
module dpram_bist_ctrl
  import dpram_pkg::*;
(
  input  logic                clk,
  input  logic                ar,
  input  logic                start,
  dpram_bist_ctrl_if.master   mem,
  output logic                busy,
  output logic                pass,
  output logic                fail,
  output logic                timeout,
  output logic [AW-1:0]       fail_addr,
  output logic [DW-1:0]       fail_data,
  output logic [1:0]          fail_phase
);

  state_t        r_state, w_state_nxt;
  phase_t        r_phase, w_phase_nxt;
  op_t           r_op, w_op_nxt;
  logic [AW-1:0] r_a, w_a_nxt;
  logic [DW-1:0] r_din, w_din_nxt;
  logic          r_rd, w_rd_nxt, r_wr, w_wr_nxt;
  logic          r_busy, w_busy_nxt, r_pass, w_pass_nxt, r_fail, w_fail_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic [AW-1:0] r_fail_addr, w_fail_addr_nxt;
  logic [DW-1:0] r_fail_data, w_fail_data_nxt;
  logic [1:0]    r_fail_phase, w_fail_phase_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic          w_load, w_step, w_up, w_tc;
  logic [AW-1:0] w_load_val, w_cnt;

  assign w_up = (r_phase != PH_R1);

  dpram_addr_seq u_addr_seq (
    .clk        (clk),
    .ar         (ar),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_step     (w_step),
    .i_up       (w_up),
    .o_addr     (w_cnt),
    .o_tc       (w_tc)
  );

  // State, registered outputs and result capture.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      r_state      <= ST_IDLE;
      r_phase      <= PH_W0;
      r_op         <= OP_WR;
      r_a          <= {AW{1'b0}};
      r_din        <= {DW{1'b0}};
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_busy       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_fail_addr  <= {AW{1'b0}};
      r_fail_data  <= {DW{1'b0}};
      r_fail_phase <= 2'd0;
      r_tmo        <= {TW{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_op         <= w_op_nxt;
      r_a          <= w_a_nxt;
      r_din        <= w_din_nxt;
      r_rd         <= w_rd_nxt;
      r_wr         <= w_wr_nxt;
      r_busy       <= w_busy_nxt;
      r_pass       <= w_pass_nxt;
      r_fail       <= w_fail_nxt;
      r_timeout    <= w_timeout_nxt;
      r_fail_addr  <= w_fail_addr_nxt;
      r_fail_data  <= w_fail_data_nxt;
      r_fail_phase <= w_fail_phase_nxt;
      r_tmo        <= w_tmo_nxt;
    end
  end

  // Next-state, sequencing, compare and timeout decisions.
  always_comb begin
    w_state_nxt      = r_state;
    w_phase_nxt      = r_phase;
    w_op_nxt         = r_op;
    w_a_nxt          = r_a;
    w_din_nxt        = r_din;
    w_rd_nxt         = r_rd;
    w_wr_nxt         = r_wr;
    w_pass_nxt       = r_pass;
    w_fail_nxt       = r_fail;
    w_timeout_nxt    = r_timeout;
    w_fail_addr_nxt  = r_fail_addr;
    w_fail_data_nxt  = r_fail_data;
    w_fail_phase_nxt = r_fail_phase;
    w_tmo_nxt        = r_tmo;
    w_load           = 1'b0;
    w_load_val       = {AW{1'b0}};
    w_step           = 1'b0;

    case (r_state)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          w_state_nxt      = ST_ISSUE;
          w_phase_nxt      = PH_W0;
          w_op_nxt         = OP_WR;
          w_load           = 1'b1;
          w_pass_nxt       = 1'b0;
          w_fail_nxt       = 1'b0;
          w_timeout_nxt    = 1'b0;
          w_fail_addr_nxt  = {AW{1'b0}};
          w_fail_data_nxt  = {DW{1'b0}};
          w_fail_phase_nxt = 2'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_ISSUE: begin
        w_a_nxt     = w_cnt;
        w_din_nxt   = (r_op == OP_WR) ? wr_word(r_phase) : r_din;
        w_rd_nxt    = (r_op == OP_RD);
        w_wr_nxt    = (r_op == OP_WR);
        w_tmo_nxt   = {TW{1'b0}};
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem.Done) begin
          w_rd_nxt = 1'b0;
          w_wr_nxt = 1'b0;
          if (r_rd && (mem.DOut != rd_word(r_phase))) begin
            w_state_nxt      = ST_FAIL;
            w_fail_nxt       = 1'b1;
            w_fail_addr_nxt  = r_a;
            w_fail_data_nxt  = mem.DOut;
            w_fail_phase_nxt = r_phase;
          end else begin
            w_state_nxt = ST_GAP;
          end
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          w_rd_nxt         = 1'b0;
          w_wr_nxt         = 1'b0;
          w_state_nxt      = ST_FAIL;
          w_fail_nxt       = 1'b1;
          w_timeout_nxt    = 1'b1;
          w_fail_addr_nxt  = r_a;
          w_fail_data_nxt  = {DW{1'b0}};
          w_fail_phase_nxt = r_phase;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_ISSUE;
        case (r_phase)
          PH_W0: begin
            if (w_tc) begin
              w_phase_nxt = PH_R0W1;
              w_op_nxt    = OP_RD;
              w_load      = 1'b1;
            end else begin
              w_step = 1'b1;
            end
          end
          PH_R0W1: begin
            // Read and write share an address; only the write moves the counter.
            if (r_op == OP_RD) begin
              w_op_nxt = OP_WR;
            end else if (w_tc) begin
              w_phase_nxt = PH_R1;
              w_op_nxt    = OP_RD;
              w_load      = 1'b1;
              w_load_val  = {AW{1'b1}};
            end else begin
              w_op_nxt = OP_RD;
              w_step   = 1'b1;
            end
          end
          PH_R1: begin
            if (w_tc) begin
              w_state_nxt = ST_PASS;
              w_pass_nxt  = 1'b1;
            end else begin
              w_step = 1'b1;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
          end
        endcase
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT) ||
                 (w_state_nxt == ST_GAP);
  end

  assign mem.A      = r_a;
  assign mem.DIn    = r_din;
  assign mem.RD     = r_rd;
  assign mem.WR     = r_wr;
  assign busy       = r_busy;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign timeout    = r_timeout;
  assign fail_addr  = r_fail_addr;
  assign fail_data  = r_fail_data;
  assign fail_phase = r_fail_phase;

endmodule

// File: tb/tb_dpram_bist_ctrl.sv
// Scoreboard bench for dpram_bist_ctrl: a behavioural DPRAM with injectable faults,
// expected results queued at start, compared by a monitor when pass or fail appears.
module tb_dpram_bist_ctrl;

  logic        clk = 1'b0;
  logic        ar;
  logic        start;
  logic        busy, pass, fail, timeout;
  logic [9:0]  fail_addr;
  logic [15:0] fail_data;
  logic [1:0]  fail_phase;

  dpram_bist_ctrl_if #(.AW(10), .DW(16)) mem_if ();

  dpram_bist_ctrl dut (
    .clk        (clk),
    .ar         (ar),
    .start      (start),
    .mem        (mem_if.master),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .fail_addr  (fail_addr),
    .fail_data  (fail_data),
    .fail_phase (fail_phase)
  );

  always #5 clk = ~clk;

  // Memory model with wait states and optional faults.
  logic [15:0] mem [0:1023];
  int          waits = 0;
  int          wcnt  = 0;
  bit          f_stuck = 1'b0, f_alias = 1'b0, f_hold = 1'b0;
  logic [9:0]  eff;

  assign eff = f_alias ? {1'b0, mem_if.A[8:0]} : mem_if.A;
  assign mem_if.Done = (mem_if.RD || mem_if.WR) && (wcnt >= waits) &&
                       !(f_hold && mem_if.WR && (mem_if.A == 10'h200));
  assign mem_if.DOut = mem[eff] & ((f_stuck && (eff == 10'h155)) ? 16'hFFFB : 16'hFFFF);

  always @(posedge clk) begin
    if (mem_if.RD || mem_if.WR) begin
      if (mem_if.Done) wcnt <= 0;
      else             wcnt <= wcnt + 1;
      if (mem_if.WR && mem_if.Done) mem[eff] <= mem_if.DIn;
    end else begin
      wcnt <= 0;
    end
  end

  typedef struct {
    logic        p, f, t;
    logic [9:0]  addr;
    logic [15:0] data;
    logic [1:0]  ph;
    int          busy_cycles;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_results = 0;
  int   viol = 0;
  int   busy_cnt = 0;
  int   streak = 0, last_streak = 0;
  logic [9:0]  last_rd_addr = 10'h0;
  logic [15:0] last_rd_data = 16'h0;
  bit          last_was_rd = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: protocol tracking and scoreboard pops on each new result.
  initial begin : monitor
    bit   prev_rd = 1'b0, prev_wr = 1'b0, prev_busy = 1'b0, prev_res = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_if.RD && mem_if.WR) viol++;
      if ((prev_rd && mem_if.WR) || (prev_wr && mem_if.RD)) viol++;
      if (busy && !prev_busy) busy_cnt = 1;
      else if (busy)          busy_cnt++;
      if ((mem_if.RD || mem_if.WR) && !mem_if.Done) begin
        streak++;
      end else begin
        if (streak != 0) last_streak = streak;
        streak = 0;
      end
      if ((mem_if.RD || mem_if.WR) && mem_if.Done) last_was_rd = mem_if.RD;
      if (mem_if.RD && mem_if.Done) begin
        last_rd_addr = mem_if.A;
        last_rd_data = mem_if.DOut;
      end
      if ((pass || fail) && !prev_res) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pass", {31'd0, pass}, {31'd0, e.p});
          check("fail", {31'd0, fail}, {31'd0, e.f});
          check("timeout", {31'd0, timeout}, {31'd0, e.t});
          check("fail_addr", {22'd0, fail_addr}, {22'd0, e.addr});
          check("fail_data", {16'd0, fail_data}, {16'd0, e.data});
          check("fail_phase", {30'd0, fail_phase}, {30'd0, e.ph});
          check("strobes_low", {30'd0, mem_if.RD, mem_if.WR}, 32'd0);
          check("busy_low", {31'd0, busy}, 32'd0);
          if (e.busy_cycles >= 0) check("busy_cycles", busy_cnt, e.busy_cycles);
        end
        n_results++;
      end
      prev_rd   = mem_if.RD;
      prev_wr   = mem_if.WR;
      prev_busy = busy;
      prev_res  = pass || fail;
    end
  end

  task automatic push(input logic p, input logic t, input logic [9:0] a,
                      input logic [15:0] d, input logic [1:0] ph, input int bc);
    exp_t e;
    e.p = p; e.f = !p; e.t = t; e.addr = a; e.data = d; e.ph = ph; e.busy_cycles = bc;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_result(input int base, input int budget);
    int k = 0;
    while (n_results == base && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_results == base) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_result: no result after %0d cycles, required one", budget);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_bus"}, {mem_if.A, mem_if.DIn, mem_if.RD, mem_if.WR, busy, pass, fail, timeout}, 32'd0);
    check({nm, "_res"}, {4'd0, fail_addr, fail_data, fail_phase}, 32'd0);
  endtask

  initial begin : guard
    #1500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin : stim
    int base;
    int k;
    ar = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    ar = 1'b1;

    // Zero-wait clean memory.
    waits = 0; viol = 0; base = n_results;
    push(1'b1, 1'b0, 10'h000, 16'h0000, 2'd0, 12288);
    pulse_start();
    wait_result(base, 13000);
    check("last_op_rd", {31'd0, last_was_rd}, 32'd1);
    check("last_rd_addr", {22'd0, last_rd_addr}, 32'h0);
    check("last_rd_data", {16'd0, last_rd_data}, 32'h5A5A);
    check("strobe_overlap", viol, 0);

    // Stuck-at-0 on data bit 2 at 0x155.
    f_stuck = 1'b1; base = n_results;
    push(1'b0, 1'b0, 10'h155, 16'hA5A1, 2'd1, -1);
    pulse_start();
    wait_result(base, 10000);
    f_stuck = 1'b0;

    // Address bit 9 ignored.
    f_alias = 1'b1; base = n_results;
    push(1'b0, 1'b0, 10'h200, 16'h5A5A, 2'd1, -1);
    pulse_start();
    wait_result(base, 10000);
    f_alias = 1'b0;

    // Done withheld on the phase-0 write to 0x200.
    f_hold = 1'b1; base = n_results;
    push(1'b0, 1'b1, 10'h200, 16'h0000, 2'd0, -1);
    pulse_start();
    wait_result(base, 3000);
    check("timeout_wait_cycles", last_streak, 255);
    f_hold = 1'b0;

    // Three wait states, start held high throughout.
    waits = 3; base = n_results;
    push(1'b1, 1'b0, 10'h000, 16'h0000, 2'd0, 24576);
    @(negedge clk) start = 1'b1;
    wait_result(base, 26000);
    @(negedge clk);
    check("restart_pass_cleared", {31'd0, pass}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_addr", {22'd0, mem_if.A}, 32'd0);
    start = 1'b0;
    k = 0;
    while (!mem_if.RD && k < 10000) begin
      @(negedge clk);
      k++;
    end
    check("reached_phase1", {31'd0, mem_if.RD}, 32'd1);
    repeat (20) @(negedge clk);

    // Asynchronous reset mid phase 1, checked before the next clock edge.
    #2 ar = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk) ar = 1'b1;
    waits = 0; base = n_results;
    push(1'b1, 1'b0, 10'h000, 16'h0000, 2'd0, 12288);
    pulse_start();
    k = 0;
    while (!(mem_if.RD || mem_if.WR) && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("rerun_first_wr", {31'd0, mem_if.WR}, 32'd1);
    check("rerun_first_addr", {22'd0, mem_if.A}, 32'd0);
    wait_result(base, 13000);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dpram_bist_ctrl.md
# dpram_bist_ctrl

Built-in self-test sequencer for the board's 1024 x 16 internal DPRAM. On a start request it takes ownership of the memory's address, data and strobe lines and runs a three-phase march test over every address. It checks each read word against the expected background and reports pass, or fail with the first failing address, data and phase. It sits between the board I/O logic (start request, pass/fail LEDs) and the DPRAM port, in place of the manual read/write path while active.

## Interface

- AW, 10: address width
- DW, 16: data width
- BG, 16'hA5A5: data background; the complement is ~BG
- TIMEOUT, 255: maximum cycles a strobe may stay high without Done

Ports:

- clk  in  1  system clock, rising edge
- ar  in  1  asynchronous active-low reset
- start  in  1  level, sampled each clk; begins a test when not busy
- Done  in  1  memory completion for the current RD/WR strobe
- DOut  in  DW  memory read data, valid in the cycle Done=1 for a read
- A  out  AW  memory address (registered)
- DIn  out  DW  memory write data (registered)
- RD, WR  out  1  read / write strobes; never both high
- busy  out  1  test in progress
- pass, fail  out  1  sticky result flags, mutually exclusive
- timeout  out  1  fail was caused by a missing Done
- fail_addr  out  AW  address of the first failure
- fail_data  out  DW  DOut captured at a miscompare (0 on timeout)
- fail_phase  out  2  phase of the first failure (0/1/2)

## Operation

- Phase 0, addresses 0 to 1023 ascending: W(BG).
- Phase 1, ascending: R(expect BG), then W(~BG), at each address.
- Phase 2, addresses 1023 down to 0: R(expect ~BG).
- Total 4096 accesses. The test stops at the first failure.
- FSM states:
  - IDLE: start=1 moves to ISSUE.
  - ISSUE: load A/DIn, raise RD or WR, go to WAIT.
  - WAIT: hold strobe, A and DIn stable until Done=1, then go to GAP.
  - GAP: strobes low; advance op/address/phase, then ISSUE, or PASS after the final phase-2 access.
  - PASS, FAIL: terminal; start=1 goes to ISSUE.
- Leaving PASS/FAIL clears pass, fail, timeout, fail_addr, fail_data and fail_phase, and restarts at phase 0, address 0.
- Compare: on a read, in the cycle Done=1, compare DOut with the expected word. On mismatch go to FAIL and capture A, DOut and phase.
- Timeout: a counter runs while in WAIT. When it reaches TIMEOUT with Done still 0, go to FAIL with timeout=1, fail_data=0, and fail_addr/fail_phase at the current values.
- Entering PASS/FAIL drops the strobes in the same transition.
- busy=1 in ISSUE, WAIT and GAP.
- start while busy is ignored. Done outside WAIT is ignored.
- Address counter wraps only at phase boundaries: 1023 to 0 at the end of phase 0; phase 2 starts at 1023.

## Timing

- All outputs are registered. Reset values are 0 for A, DIn, RD, WR, busy, pass, fail, timeout, fail_addr, fail_data and fail_phase.
- Reset is asynchronous. Asserting ar mid-test forces all outputs to 0 immediately and returns the FSM to IDLE; no partial result is kept.
- Start to first strobe: start sampled at edge n puts RD/WR high after edge n+1.
- Strobe protocol:
  - A strobe rises after an edge and Done is sampled at each following edge.
  - When Done=1 is sampled, the strobe is low for exactly one cycle (GAP), and the next strobe rises on the following edge.
  - With a zero-wait memory (Done=1 at the first sample) each access takes 3 cycles.
  - The full test takes 12288 cycles plus 1; pass asserts on the edge after the last GAP.
- A timeout occurs after TIMEOUT consecutive WAIT cycles with Done=0.

## Structure

- A shared package dpram_pkg holds:
  - state encodings (IDLE, ISSUE, WAIT, GAP, PASS, FAIL)
  - phase constants (PH_W0=0, PH_R0W1=1, PH_R1=2)
  - op constants (OP_RD, OP_WR)
  - default AW/DW/BG
- One sub-module, dpram_addr_seq: a loadable up/down AW-bit address counter with step enable and terminal-count output (1023 going up, 0 going down).
- Compare, capture and timeout logic live in the top.

## Test plan

- Zero-wait ideal memory model with one start pulse. Required:
  - busy high for 12288 cycles, then pass=1, fail=0.
  - Last access is RD at A=0 returning 16'h5A5A.
  - RD and WR never high together or in adjacent cycles.
- Address 0x155 data bit 2 stuck at 0. Required: fail=1, fail_phase=1, fail_addr=0x155, fail_data=16'hA5A1, timeout=0, strobes low.
- Model ignores address bit 9 (0x200 aliases 0x000). Required: fail in phase 1 at fail_addr=0x200 with fail_data=16'h5A5A.
- Done withheld on the phase-0 write to 0x200. Required: after 255 WAIT cycles, fail=1, timeout=1, fail_addr=0x200, fail_phase=0, fail_data=0.
- Memory with 3 wait states and start held high throughout. Required:
  - no restart while busy.
  - pass=1 at completion.
  - the next start clears pass and raises busy one edge later, with A=0.
- ar pulsed low mid phase 1. Required:
  - all outputs 0 immediately.
  - a new start reruns from phase 0, address 0, and passes.
